// File: rtl/arbiter_request_queue.sv
// Requestor-side FIFO in front of the round-robin arbiter: drives one request bit and forwards granted entries.
// Optional starvation detection is enabled by defining ARBITER_STARVE_DETECT_EN.
module arbiter_request_queue #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             enqueue_en,
   input  logic [WIDTH-1:0] enqueue_data,
   output logic             full,
   output logic             almost_full,
   output logic             empty,
   output logic             request,
   input  logic             grant,
   output logic             send_valid,
   output logic [WIDTH-1:0] send_data,
   output logic             starved
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
      $error("arbiter_request_queue: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
   end

   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] entries [DEPTH];

   logic dequeue;
   logic do_dequeue;
   logic do_enqueue;

   assign full        = (count == CNT_W'(DEPTH));
   assign almost_full = (count >= CNT_W'(DEPTH - 1));
   assign empty       = (count == '0);
   assign request     = !empty;

   // Flush wins over both ports; a full queue still accepts when the same edge frees a slot.
   assign dequeue    = grant & request;
   assign do_dequeue = dequeue & ~flush;
   assign do_enqueue = enqueue_en & ~flush & (~full | dequeue);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else if (flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (do_enqueue) begin
            tail_ptr <= tail_ptr + PTR_W'(1);
         end
         if (do_dequeue) begin
            head_ptr <= head_ptr + PTR_W'(1);
         end
         case ({do_enqueue, do_dequeue})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (do_enqueue) begin
         entries[tail_ptr] <= enqueue_data;
      end
   end

   // send_data holds its last payload; only send_valid marks a fresh transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         send_valid <= 1'b0;
         send_data  <= '0;
      end else begin
         send_valid <= do_dequeue;
         if (do_dequeue) begin
            send_data <= entries[head_ptr];
         end
      end
   end

`ifdef ARBITER_STARVE_DETECT_EN
   localparam int WAIT_W = $clog2(STARVE_LIMIT) + 1;

   logic [WAIT_W-1:0] wait_count;
   logic [WAIT_W-1:0] wait_next;

   always_comb begin
      wait_next = wait_count;
      if (grant || !request || flush) begin
         wait_next = '0;
      end else if (wait_count != WAIT_W'(STARVE_LIMIT)) begin
         wait_next = wait_count + WAIT_W'(1);
      end
   end

   // starved is registered from the next count so it rises on the edge the limit is reached.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_count <= '0;
         starved    <= 1'b0;
      end else begin
         wait_count <= wait_next;
         starved    <= (wait_next == WAIT_W'(STARVE_LIMIT));
      end
   end
`else
   assign starved = 1'b0;
`endif

`ifndef SYNTHESIS
   grant_while_empty: assert property (@(posedge clk) disable iff (reset) !(grant && empty))
      else $warning("arbiter_request_queue: grant received while queue empty");

   enqueue_while_full: assert property (@(posedge clk) disable iff (reset)
                                        !(enqueue_en && full && !dequeue && !flush))
      else $warning("arbiter_request_queue: enqueue while full, payload %h dropped", enqueue_data);
`endif

endmodule

// File: tb/tb_arbiter_request_queue.sv
// Self-checking bench for arbiter_request_queue: table-driven flag checks plus a payload scoreboard.
module tb_arbiter_request_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
`ifdef ARBITER_STARVE_DETECT_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic             flush;
   logic             enqueue_en;
   logic [WIDTH-1:0] enqueue_data;
   logic             full;
   logic             almost_full;
   logic             empty;
   logic             request;
   logic             grant;
   logic             send_valid;
   logic [WIDTH-1:0] send_data;
   logic             starved;

   arbiter_request_queue #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .STARVE_LIMIT(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .enqueue_en(enqueue_en),
      .enqueue_data(enqueue_data),
      .full(full),
      .almost_full(almost_full),
      .empty(empty),
      .request(request),
      .grant(grant),
      .send_valid(send_valid),
      .send_data(send_data),
      .starved(starved)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             flush;
      logic             enq;
      logic [WIDTH-1:0] data;
      logic             grant;
      logic             exp_full;
      logic             exp_af;
      logic             exp_empty;
      logic             exp_req;
      logic             exp_sv;
      logic             exp_starved;
   } vec_t;

   vec_t             vecs[$];
   logic [WIDTH-1:0] sb[$];
   int               checks   = 0;
   int               failures = 0;

   function automatic vec_t mk(input logic fl, input logic en, input logic [WIDTH-1:0] d, input logic gr,
                               input logic fu, input logic af, input logic em, input logic rq,
                               input logic sv, input logic st);
      vec_t v;
      v.flush = fl; v.enq = en; v.data = d; v.grant = gr;
      v.exp_full = fu; v.exp_af = af; v.exp_empty = em; v.exp_req = rq;
      v.exp_sv = sv; v.exp_starved = st;
      return v;
   endfunction

   task automatic checkBit(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkWord(input string name, input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive on the falling edge and update the scoreboard with what the queue should accept.
   task automatic applyStimulus(input vec_t v);
      bit deq;
      @(negedge clk);
      flush        = v.flush;
      enqueue_en   = v.enq;
      enqueue_data = v.data;
      grant        = v.grant;
      if (v.flush) begin
         sb.delete();
      end else begin
         deq = v.grant && (sb.size() > 0);
         if (v.enq && ((sb.size() < DEPTH) || deq)) begin
            sb.push_back(v.data);
         end
      end
   endtask

   task automatic checkOutput(input vec_t v, input string tag);
      @(posedge clk);
      #1;
      checkBit({tag, ".full"},        full,        v.exp_full);
      checkBit({tag, ".almost_full"}, almost_full, v.exp_af);
      checkBit({tag, ".empty"},       empty,       v.exp_empty);
      checkBit({tag, ".request"},     request,     v.exp_req);
      checkBit({tag, ".send_valid"},  send_valid,  v.exp_sv);
      checkBit({tag, ".starved"},     starved,     v.exp_starved);
      if (send_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s.send_data: got send of %h expected no pending entry", tag, send_data);
         end else begin
            checkWord({tag, ".send_data"}, send_data, sb.pop_front());
         end
      end
   endtask

   task automatic runVec(input vec_t v, input string tag);
      applyStimulus(v);
      checkOutput(v, tag);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clk          = 1'b0;
      reset        = 1'b1;
      flush        = 1'b0;
      enqueue_en   = 1'b0;
      enqueue_data = '0;
      grant        = 1'b0;

      #2;
      checkBit("reset.empty",       empty,       1'b1);
      checkBit("reset.full",        full,        1'b0);
      checkBit("reset.almost_full", almost_full, 1'b0);
      checkBit("reset.request",     request,     1'b0);
      checkBit("reset.send_valid",  send_valid,  1'b0);
      checkWord("reset.send_data",  send_data,   '0);
      checkBit("reset.starved",     starved,     1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Single enqueue, then drain with one grant
      vecs.push_back(mk(0, 1, 32'hA5A5_0001, 0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,         0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,         1,  0, 0, 1, 0, 1, 0));
      // Fill to DEPTH, then four back-to-back grants
      vecs.push_back(mk(0, 1, 32'h1, 0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h2, 0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h3, 0,  0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h4, 0,  1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0, 1,  0, 1, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 1,  0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 1,  0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 1,  0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 0,  0, 0, 1, 0, 0, 0));
      // Full queue with simultaneous enqueue and grant
      vecs.push_back(mk(0, 1, 32'h1, 0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h2, 0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h3, 0,  0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h4, 0,  1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h5, 1,  1, 1, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 1,  0, 1, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 1,  0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 1,  0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0, 1,  0, 0, 1, 0, 1, 0));
      // Overflow without grant is dropped
      vecs.push_back(mk(0, 1, 32'h11, 0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h12, 0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h13, 0,  0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h14, 0,  1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h9,  0,  1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,  1,  0, 1, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,  1,  0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,  1,  0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,  1,  0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,  0,  0, 0, 1, 0, 0, 0));
      // Flush with coincident grant, then a fresh entry goes first
      vecs.push_back(mk(0, 1, 32'h21, 0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h22, 0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h23, 0,  0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0,  1,  0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h7,  0,  0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,  1,  0, 0, 1, 0, 1, 0));
      // Grant on empty queue, and flush beating an enqueue
      vecs.push_back(mk(0, 0, 32'h0,  1,  0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 32'h33, 0,  0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,  0,  0, 0, 1, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], $sformatf("vec%0d", i));
      end

      // Asynchronous reset while entries are pending and a send is on the outputs
      runVec(mk(0, 1, 32'h41, 0,  0, 0, 0, 1, 0, 0), "rst_mid.enq0");
      runVec(mk(0, 1, 32'h42, 1,  0, 0, 0, 1, 1, 0), "rst_mid.enq1");
      #2;
      reset      = 1'b1;
      enqueue_en = 1'b0;
      grant      = 1'b0;
      #1;
      checkBit("rst_mid.empty",      empty,      1'b1);
      checkBit("rst_mid.request",    request,    1'b0);
      checkBit("rst_mid.send_valid", send_valid, 1'b0);
      checkWord("rst_mid.send_data", send_data,  '0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      runVec(mk(0, 0, 32'h0,  0,  0, 0, 1, 0, 0, 0), "rst_mid.after");
      runVec(mk(0, 1, 32'h43, 0,  0, 0, 0, 1, 0, 0), "rst_mid.enq2");
      runVec(mk(0, 0, 32'h0,  1,  0, 0, 1, 0, 1, 0), "rst_mid.send");

      // One entry waiting without grant; starved only rises when detection is built in
      runVec(mk(0, 1, 32'h55, 0,  0, 0, 0, 1, 0, 0), "starve.enq");
      for (int i = 1; i <= 65; i++) begin
         runVec(mk(0, 0, 32'h0, 0,  0, 0, 0, 1, 0, STARVE_ON && (i >= 64)), $sformatf("starve.wait%0d", i));
      end
      runVec(mk(0, 0, 32'h0,  1,  0, 0, 1, 0, 1, 0), "starve.grant");

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL sb_drained: got %0d entries never sent expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arbiter_request_queue.md
Name: arbiter_request_queue

Overview:
Requestor-side companion to the round-robin arbiter. It buffers transactions from one local producer and drives that requestor's bit of the arbiter request vector. It consumes the matching bit of the arbiter's one-hot grant and forwards the granted transaction one cycle later as a registered send strobe. One instance sits between each unit (thread, cache miss path) and the shared resource.

Parameters:
WIDTH, 32, bits per queued transaction
DEPTH, 4, queue entries; power of two, >= 2
STARVE_LIMIT, 64, cycles of request-without-grant before starved asserts; used only with the optional feature

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
flush  input  1  discard all pending entries
enqueue_en  input  1  push enqueue_data this cycle
enqueue_data  input  WIDTH  transaction payload
full  output  1  count == DEPTH
almost_full  output  1  count >= DEPTH-1
empty  output  1  count == 0
request  output  1  to arbiter request bit; combinational, equals !empty
grant  input  1  this requestor's bit of arbiter grant_oh; same-cycle response to request
send_valid  output  1  registered; head transaction was granted last cycle
send_data  output  WIDTH  registered payload accompanying send_valid
starved  output  1  starvation flag; 0 when the optional feature is off

Behaviour:
- One clock, clk. Reset is asynchronous and active-high, named reset. All state uses posedge clk, posedge reset.
- Reset state:
  - head/tail pointers = 0, count = 0
  - empty=1, full=0, almost_full=0, request=0
  - send_valid=0, send_data=0, starved=0
- Storage: circular buffer, DEPTH entries.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is log2(DEPTH)+1 bits.
- Enqueue:
  - When enqueue_en=1 and accepted, the entry is written at tail on the clock edge; tail and count update.
  - No bypass: request rises the cycle after the first enqueue into an empty queue.
- Dequeue:
  - dequeue = grant & request.
  - On the edge: head advances, count decrements, send_valid<=1, send_data<=entry[head].
  - send_valid is 0 in every cycle that did not follow a dequeue.
  - Back-to-back grants produce back-to-back send_valid, one entry per cycle, in FIFO order.
- grant while empty: ignored, no state change. Simulation assertion fires.
- Simultaneous enqueue and dequeue:
  - count unchanged, both pointers advance.
  - Legal when full: the dequeue frees the slot that same edge.
- enqueue_en while full without grant:
  - data dropped, state unchanged.
  - Simulation assertion fires (protocol error; producers must honour full/almost_full).
- Flush:
  - head=tail=0, count=0 on the edge; request is 0 the next cycle.
  - Priority: flush > enqueue/dequeue in the same cycle.
  - A grant coincident with flush does not produce send_valid.
- Reset mid-operation: all queued entries are lost and outputs return to reset values immediately (asynchronous).
- Flags full, almost_full and empty are decoded from the registered count (no combinational input dependence). request depends only on count.

Optional Feature:
Macro ARBITER_STARVE_DETECT_EN.
- Defined:
  - A wait counter of log2(STARVE_LIMIT)+1 bits increments every cycle with request=1 and grant=0, saturating at STARVE_LIMIT.
  - It clears to 0 on any cycle with grant=1, request=0, or flush=1.
  - starved is registered and equals (counter == STARVE_LIMIT).
  - starved deasserts the cycle after the clearing event.
- Not defined: no counter logic; starved tied to 0.

Test Plan:
- Reset, then enqueue 0xA5A5_0001 with grant held 0 -> request=1 from cycle 1; empty=0, almost_full=0; send_valid stays 0.
- Enqueue 0x1,0x2,0x3,0x4 (DEPTH=4), then grant=1 for 4 cycles -> full=1 after 4th enqueue; send_valid=1 on 4 consecutive cycles with send_data 0x1,0x2,0x3,0x4; empty=1, request=0 afterward.
- Full queue, enqueue 0x5 with grant=1 same cycle -> count stays 4; subsequent sends are 0x2,0x3,0x4,0x5 (wrap of tail to index 0 verified).
- Full queue, enqueue 0x9 with grant=0 -> 0x9 dropped, count=4, assertion reported; drain yields only the original 4 entries.
- 3 entries queued, flush=1 with grant=1 same cycle -> next cycle empty=1, request=0, send_valid=0; a later enqueue of 0x7 is sent first.
- With ARBITER_STARVE_DETECT_EN and STARVE_LIMIT=64: 1 entry queued, grant held 0 -> starved=1 exactly after 64 waiting cycles; grant=1 -> starved=0 next cycle.
